// File: rtl/hazard_sched.sv
// Central hazard scheduler for the 5-stage RV32 pipeline: hold/clear controls for PC and
// segment registers, data-cache miss stall FSM with timeout, and performance counters.
module hazard_sched #(
  parameter int unsigned MISS_TIMEOUT = 255,
  parameter logic [1:0]  WB_SEL_CACHE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [1:0]  src_reg_en_ID,
  input  logic [4:0]  rd_EX,
  input  logic [1:0]  wb_select_EX,
  input  logic        reg_write_en_EX,
  input  logic        br_EX,
  input  logic        jalr_EX,
  input  logic        jal_ID,
  input  logic        dcache_req_MEM,
  input  logic        dcache_miss,
  input  logic        dcache_done,
  output logic        bubbleF,
  output logic        bubbleD,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        miss_timeout,
  output logic [31:0] miss_count,
  output logic [31:0] stall_cycles
);

  localparam int unsigned WAIT_W     = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MISS_TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t            stall_state;
  logic [WAIT_W-1:0] wait_cnt;

  logic miss_start;
  logic miss_stall;
  logic timeout_hit;
  logic redirect;
  logic load_use;

  // Hazard detection; a refill completing in the same cycle as the timeout takes precedence.
  always_comb begin
    miss_start  = (stall_state == IDLE) && dcache_req_MEM && dcache_miss;
    miss_stall  = miss_start || ((stall_state == MISS) && !dcache_done);
    timeout_hit = (stall_state == MISS) && !dcache_done && (wait_cnt == WAIT_LIMIT);
    redirect    = br_EX || jalr_EX;
    load_use    = reg_write_en_EX && (wb_select_EX == WB_SEL_CACHE) && (rd_EX != 5'd0) &&
                  ((src_reg_en_ID[0] && (rs1_ID == rd_EX)) ||
                   (src_reg_en_ID[1] && (rs2_ID == rd_EX)));
  end

  // Miss FSM, timeout flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_state  <= IDLE;
      wait_cnt     <= '0;
      miss_timeout <= 1'b0;
      miss_count   <= '0;
      stall_cycles <= '0;
    end else begin
      case (stall_state)
        IDLE: begin
          if (miss_start) begin
            stall_state <= MISS;
            wait_cnt    <= '0;
            miss_count  <= miss_count + 32'd1;
          end
        end
        MISS: begin
          stall_cycles <= stall_cycles + 32'd1;
          wait_cnt     <= wait_cnt + WAIT_W'(1);
          if (dcache_done) begin
            stall_state <= IDLE;
          end else if (timeout_hit) begin
            stall_state  <= IDLE;
            miss_timeout <= 1'b1;
          end
        end
        default: stall_state <= IDLE;
      endcase
    end
  end

  // Zero-latency pipeline controls, in priority order.
  always_comb begin
    bubbleF = 1'b0;
    bubbleD = 1'b0;
    bubbleE = 1'b0;
    bubbleM = 1'b0;
    bubbleW = 1'b0;
    flushF  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    flushW  = 1'b0;
    if (rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (miss_stall) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      bubbleE = 1'b1;
      bubbleM = 1'b1;
      flushW  = 1'b1;
    end else if (redirect) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (load_use) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end else if (jal_ID) begin
      flushD = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the scheduling rules.
module tb_hazard_sched;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic [1:0]  src_reg_en_ID, wb_select_EX;
  logic        reg_write_en_EX, br_EX, jalr_EX, jal_ID;
  logic        dcache_req_MEM, dcache_miss, dcache_done;
  logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        miss_timeout;
  logic [31:0] miss_count, stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  bit          m_in_miss;
  int          m_waited;
  bit          m_timeout;
  logic [31:0] m_misses;
  logic [31:0] m_stalls;

  hazard_sched #(.MISS_TIMEOUT(TO), .WB_SEL_CACHE(2'b01)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .src_reg_en_ID(src_reg_en_ID),
    .rd_EX(rd_EX), .wb_select_EX(wb_select_EX), .reg_write_en_EX(reg_write_en_EX),
    .br_EX(br_EX), .jalr_EX(jalr_EX), .jal_ID(jal_ID),
    .dcache_req_MEM(dcache_req_MEM), .dcache_miss(dcache_miss), .dcache_done(dcache_done),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .miss_timeout(miss_timeout), .miss_count(miss_count), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
    src_reg_en_ID = '0; wb_select_EX = '0; reg_write_en_EX = 1'b0;
    br_EX = 1'b0; jalr_EX = 1'b0; jal_ID = 1'b0;
    dcache_req_MEM = 1'b0; dcache_miss = 1'b0; dcache_done = 1'b0;
  endtask

  // Expected controls as {W,M,E,D,F} vectors, from the priority rules.
  task automatic expected(output logic [4:0] eb, output logic [4:0] ef);
    bit stall, hazard;
    stall  = (!m_in_miss && dcache_req_MEM && dcache_miss) || (m_in_miss && !dcache_done);
    hazard = reg_write_en_EX && wb_select_EX == 2'b01 && rd_EX != 0 &&
             ((src_reg_en_ID[0] && rs1_ID == rd_EX) || (src_reg_en_ID[1] && rs2_ID == rd_EX));
    eb = 5'b00000; ef = 5'b00000;
    if (rst)                  ef = 5'b11111;
    else if (stall)           begin eb = 5'b01111; ef = 5'b10000; end
    else if (br_EX || jalr_EX) ef = 5'b00110;
    else if (hazard)          begin eb = 5'b00011; ef = 5'b00100; end
    else if (jal_ID)          ef = 5'b00010;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_in_miss = 0; m_waited = 0; m_timeout = 0; m_misses = 0; m_stalls = 0;
    end else if (!m_in_miss) begin
      if (dcache_req_MEM && dcache_miss) begin
        m_in_miss = 1; m_waited = 0; m_misses = m_misses + 1;
      end
    end else begin
      m_stalls = m_stalls + 1;
      m_waited++;
      if (dcache_done) m_in_miss = 0;
      else if (m_waited == TO) begin m_in_miss = 0; m_timeout = 1; end
    end
  endtask

  // Compare mid-cycle, then advance one clock edge with the same inputs.
  task automatic cycle(input string tag);
    logic [4:0] eb, ef;
    #4;
    expected(eb, ef);
    check({tag, ".bubble"}, 32'({bubbleW, bubbleM, bubbleE, bubbleD, bubbleF}), 32'(eb));
    check({tag, ".flush"},  32'({flushW, flushM, flushE, flushD, flushF}), 32'(ef));
    check({tag, ".timeout"}, 32'(miss_timeout), 32'(m_timeout));
    check({tag, ".misses"}, miss_count, m_misses);
    check({tag, ".stalls"}, stall_cycles, m_stalls);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    clear_inputs();
    m_in_miss = 0; m_waited = 0; m_timeout = 0; m_misses = 0; m_stalls = 0;
    @(posedge clk); #1;

    // Miss lifecycle: 4 stalled cycles, done cycle unstalled.
    rst = 1'b1; cycle("t1_rst"); rst = 1'b0;
    check("t1_reset_count", miss_count, 32'd0);
    dcache_req_MEM = 1'b1; dcache_miss = 1'b1; cycle("t1_miss");
    dcache_req_MEM = 1'b0; dcache_miss = 1'b0;
    repeat (3) cycle("t1_wait");
    dcache_done = 1'b1; cycle("t1_done"); dcache_done = 1'b0;
    cycle("t1_after");
    check("t1_miss_count", miss_count, 32'd1);
    check("t1_stall_cycles", stall_cycles, 32'd4);

    // Load-use hazard, then with x0 destination.
    wb_select_EX = 2'b01; reg_write_en_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; src_reg_en_ID = 2'b10;
    #4;
    check("t2_lu_pattern", 32'({bubbleF, bubbleD, flushE, bubbleE, flushD}), 32'b11100);
    #1; @(posedge clk); model_edge(); #1;
    cycle("t2_lu");
    rd_EX = 5'd0; rs2_ID = 5'd0; cycle("t2_x0");
    rd_EX = 5'd5; rs2_ID = 5'd5;

    // Priority: redirect beats load-use, miss beats everything.
    br_EX = 1'b1; cycle("t3_br_lu");
    dcache_req_MEM = 1'b1; dcache_miss = 1'b1; cycle("t3_miss_all");
    clear_inputs();
    dcache_done = 1'b1; cycle("t3_done"); dcache_done = 1'b0;

    // Timeout: 8 MISS cycles, flag sticky until reset.
    dcache_req_MEM = 1'b1; dcache_miss = 1'b1; cycle("t4_miss");
    dcache_req_MEM = 1'b0; dcache_miss = 1'b0;
    repeat (TO) cycle("t4_wait");
    check("t4_timeout_set", 32'(miss_timeout), 32'd1);
    repeat (20) cycle("t4_sticky");
    check("t4_still_set", 32'(miss_timeout), 32'd1);
    rst = 1'b1; cycle("t4_rst"); rst = 1'b0;
    check("t4_cleared", 32'(miss_timeout), 32'd0);

    // Reset on the 2nd MISS cycle.
    dcache_req_MEM = 1'b1; dcache_miss = 1'b1; cycle("t5_miss");
    dcache_req_MEM = 1'b0; dcache_miss = 1'b0;
    cycle("t5_wait1");
    rst = 1'b1; cycle("t5_rst"); rst = 1'b0;
    cycle("t5_idle");
    check("t5_stalls_zero", stall_cycles, 32'd0);

    // Back-to-back misses, then jal alone.
    dcache_req_MEM = 1'b1; dcache_miss = 1'b1; cycle("t6_miss1");
    dcache_req_MEM = 1'b0; dcache_miss = 1'b0;
    cycle("t6_wait");
    dcache_done = 1'b1; cycle("t6_done1"); dcache_done = 1'b0;
    dcache_req_MEM = 1'b1; dcache_miss = 1'b1; cycle("t6_miss2");
    dcache_req_MEM = 1'b0; dcache_miss = 1'b0;
    cycle("t6_wait2");
    dcache_done = 1'b1; cycle("t6_done2"); dcache_done = 1'b0;
    check("t6_miss_count", miss_count, 32'd2);
    jal_ID = 1'b1; cycle("t6_jal"); jal_ID = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(199) == 0);
      rs1_ID          = 5'($urandom_range(7));
      rs2_ID          = 5'($urandom_range(7));
      rd_EX           = 5'($urandom_range(7));
      src_reg_en_ID   = 2'($urandom);
      wb_select_EX    = 2'($urandom);
      reg_write_en_EX = 1'($urandom);
      br_EX           = ($urandom_range(9) == 0);
      jalr_EX         = ($urandom_range(9) == 0);
      jal_ID          = ($urandom_range(7) == 0);
      dcache_req_MEM  = ($urandom_range(2) == 0);
      dcache_miss     = 1'($urandom);
      dcache_done     = ($urandom_range(9) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
